// File: rtl/adpcm_channel_scheduler.sv
// Shares one stateless IMA-ADPCM encode core across NUM_CH sample streams. The block holds the
// per-channel predictor context and packs pairs of 4-bit codes into bytes tagged with a channel.

module adpcm_ch_ctx (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        wr_en,
    input  logic [15:0] wr_pred,
    input  logic [6:0]  wr_index,
    input  logic [3:0]  wr_code,
    output logic [15:0] pred,
    output logic [6:0]  index,
    output logic        half,
    output logic [3:0]  lo
);
    // A clear wins over a same-cycle write-back, so that encode's code is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            pred  <= '0;
            index <= '0;
            half  <= 1'b0;
            lo    <= '0;
        end else if (clear) begin
            pred  <= '0;
            index <= '0;
            half  <= 1'b0;
        end else if (wr_en) begin
            pred  <= wr_pred;
            index <= wr_index;
            half  <= ~half;
            if (!half)
                lo <= wr_code;
        end
    end
endmodule

module adpcm_channel_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    s_valid,
    output logic [NUM_CH-1:0]    s_ready,
    input  logic [16*NUM_CH-1:0] s_sample,
    input  logic [NUM_CH-1:0]    ch_clear,
    output logic [15:0]          core_sample,
    output logic [15:0]          core_pred,
    output logic [6:0]           core_index,
    input  logic [3:0]           core_code,
    input  logic [15:0]          core_next_pred,
    input  logic [6:0]           core_next_index,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [7:0]           m_data,
    output logic [CH_W-1:0]      m_ch
);
    typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;

    state_t                  state;
    logic [CH_W-1:0]         last_grant;
    logic [CH_W-1:0]         cur_ch;
    logic                    grant_any;
    logic [CH_W-1:0]         grant_ch;
    logic [15:0]             sel_sample;
    logic [NUM_CH-1:0]       enc_wr;
    logic [NUM_CH-1:0][15:0] ctx_pred;
    logic [NUM_CH-1:0][6:0]  ctx_index;
    logic [NUM_CH-1:0]       ctx_half;
    logic [NUM_CH-1:0][3:0]  ctx_lo;

    // Round-robin search starting one past the last grant.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_ch  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_grant) + k) % NUM_CH;
            if (!grant_any && s_valid[CH_W'(idx)]) begin
                grant_any = 1'b1;
                grant_ch  = CH_W'(idx);
            end
        end
    end

    always_comb begin
        sel_sample = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (grant_ch == CH_W'(i))
                sel_sample = s_sample[16*i +: 16];
    end

    always_comb begin
        s_ready = '0;
        if (state == IDLE && grant_any)
            s_ready[grant_ch] = 1'b1;
    end

    always_comb begin
        enc_wr = '0;
        if (state == ENC)
            enc_wr[cur_ch] = 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ctx
        adpcm_ch_ctx u_ctx (
            .clk      (clk),
            .reset    (reset),
            .clear    (ch_clear[i]),
            .wr_en    (enc_wr[i]),
            .wr_pred  (core_next_pred),
            .wr_index (core_next_index),
            .wr_code  (core_code),
            .pred     (ctx_pred[i]),
            .index    (ctx_index[i]),
            .half     (ctx_half[i]),
            .lo       (ctx_lo[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= CH_W'(NUM_CH - 1);
            cur_ch      <= '0;
            core_sample <= '0;
            core_pred   <= '0;
            core_index  <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_ch        <= '0;
        end else begin
            case (state)
                IDLE: if (grant_any) begin
                    last_grant  <= grant_ch;
                    cur_ch      <= grant_ch;
                    core_sample <= sel_sample;
                    // A clear landing on the grant edge must already be visible to this encode.
                    core_pred   <= ch_clear[grant_ch] ? '0 : ctx_pred[grant_ch];
                    core_index  <= ch_clear[grant_ch] ? '0 : ctx_index[grant_ch];
                    state       <= ENC;
                end
                ENC: begin
                    if (ch_clear[cur_ch] || !ctx_half[cur_ch]) begin
                        state <= IDLE;
                    end else begin
                        m_data  <= {core_code, ctx_lo[cur_ch]};
                        m_ch    <= cur_ch;
                        m_valid <= 1'b1;
                        state   <= OUT;
                    end
                end
                OUT: if (m_ready) begin
                    m_valid <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adpcm_channel_scheduler.sv
// Directed bench for adpcm_channel_scheduler, driven by a behavioural IMA-ADPCM encode core.

module tb_adpcm_channel_scheduler;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_CH-1:0]    s_valid;
    logic [NUM_CH-1:0]    s_ready;
    logic [16*NUM_CH-1:0] s_sample;
    logic [NUM_CH-1:0]    ch_clear;
    logic [15:0]          core_sample;
    logic [15:0]          core_pred;
    logic [6:0]           core_index;
    logic [3:0]           core_code;
    logic [15:0]          core_next_pred;
    logic [6:0]           core_next_index;
    logic                 m_valid;
    logic                 m_ready;
    logic [7:0]           m_data;
    logic [CH_W-1:0]      m_ch;

    int checks = 0;
    int errors = 0;

    adpcm_channel_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_sample        (s_sample),
        .ch_clear        (ch_clear),
        .core_sample     (core_sample),
        .core_pred       (core_pred),
        .core_index      (core_index),
        .core_code       (core_code),
        .core_next_pred  (core_next_pred),
        .core_next_index (core_next_index),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .m_ch            (m_ch)
    );

    always #5 clk = ~clk;

    int step_tbl [0:88] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
        19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
        130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
        337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
        876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
        2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
        5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
        15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };

    // Stateless IMA-ADPCM encode core.
    always_comb begin
        int st, d, vp, p, ix;
        logic [3:0] c;
        st = step_tbl[(int'(core_index) > 88) ? 88 : int'(core_index)];
        d  = int'($signed(core_sample)) - int'($signed(core_pred));
        c  = 4'd0;
        if (d < 0) begin c[3] = 1'b1; d = -d; end
        vp = st >>> 3;
        if (d >= st) begin c[2] = 1'b1; d = d - st; vp = vp + st; end
        st = st >>> 1;
        if (d >= st) begin c[1] = 1'b1; d = d - st; vp = vp + st; end
        st = st >>> 1;
        if (d >= st) begin c[0] = 1'b1; vp = vp + st; end
        p = int'($signed(core_pred)) + (c[3] ? -vp : vp);
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
        case (c[2:0])
            3'd4:    ix = int'(core_index) + 2;
            3'd5:    ix = int'(core_index) + 4;
            3'd6:    ix = int'(core_index) + 6;
            3'd7:    ix = int'(core_index) + 8;
            default: ix = int'(core_index) - 1;
        endcase
        if (ix < 0)  ix = 0;
        if (ix > 88) ix = 88;
        core_code       = c;
        core_next_pred  = p[15:0];
        core_next_index = ix[6:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        s_valid  = '0;
        ch_clear = '0;
        m_ready  = 1'b1;
        reset    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Offers one sample on channel ch; returns 2 time units into the ENC cycle.
    task automatic send(input int ch, input logic [15:0] smp);
        int n;
        n = 0;
        s_valid[ch] = 1'b1;
        s_sample[16*ch +: 16] = smp;
        #1;
        while (!s_ready[ch] && n < 20) begin
            tick();
            n++;
        end
        chk("grant", 32'(s_ready), 32'(1) << ch);
        tick();
        s_valid[ch] = 1'b0;
    endtask

    int g_q[$];
    int ch_q[$];
    int d_q[$];
    int exp_d[4] = '{32'h00, 32'h77, 32'hFF, 32'h05};

    initial begin
        s_valid  = '0;
        s_sample = '0;
        ch_clear = '0;
        m_ready  = 1'b1;
        reset    = 1'b1;
        tick();
        tick();
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_m_ch", 32'(m_ch), 0);
        chk("rst_core_sample", 32'(core_sample), 0);
        chk("rst_core_pred", 32'(core_pred), 0);
        chk("rst_core_index", 32'(core_index), 0);
        reset = 1'b0;
        tick();

        // Two zero samples on ch0 give a zero byte and leave the index at 0.
        send(0, 16'h0000);
        chk("z1_core_index", 32'(core_index), 0);
        chk("z1_m_valid", 32'(m_valid), 0);
        tick();
        send(0, 16'h0000);
        chk("z2_s_ready_enc", 32'(s_ready), 0);
        tick();
        chk("z2_m_valid", 32'(m_valid), 1);
        chk("z2_m_data", 32'(m_data), 32'h00);
        chk("z2_m_ch", 32'(m_ch), 0);
        tick();
        chk("z2_m_valid_drop", 32'(m_valid), 0);
        send(0, 16'h0000);
        chk("z3_core_index", 32'(core_index), 0);
        tick();

        // Full-scale positive steps, then two zeros from the adapted context.
        do_reset();
        send(0, 16'h7FFF);
        chk("p1_core_sample", 32'(core_sample), 32'h7FFF);
        chk("p1_core_code", 32'(core_code), 7);
        tick();
        send(0, 16'h7FFF);
        chk("p2_core_index", 32'(core_index), 8);
        chk("p2_core_pred", 32'(core_pred), 32'h000B);
        tick();
        chk("p2_m_valid", 32'(m_valid), 1);
        chk("p2_m_data", 32'(m_data), 32'h77);
        tick();
        send(0, 16'h0000);
        chk("p3_core_pred", 32'(core_pred), 32'h0029);
        chk("p3_core_index", 32'(core_index), 16);
        tick();
        send(0, 16'h0000);
        tick();
        chk("p4_m_data", 32'(m_data), 32'h8C);
        tick();

        // All channels request continuously.
        do_reset();
        s_sample = {16'h0008, 16'h8000, 16'h7FFF, 16'h0000};
        s_valid  = 4'hF;
        #1;
        for (int n = 0; n < 80 && ch_q.size() < 4; n++) begin
            if (s_ready != '0) g_q.push_back($clog2(s_ready));
            if (m_valid && m_ready) begin
                ch_q.push_back(int'(m_ch));
                d_q.push_back(int'(m_data));
            end
            tick();
        end
        s_valid = '0;
        chk("rr_grant_count", 32'(g_q.size()), 8);
        chk("rr_byte_count", 32'(ch_q.size()), 4);
        for (int i = 0; i < g_q.size() && i < 8; i++)
            chk("rr_grant_order", 32'(g_q[i]), 32'(i % 4));
        for (int i = 0; i < ch_q.size() && i < 4; i++) begin
            chk("rr_m_ch", 32'(ch_q[i]), 32'(i));
            chk("rr_m_data", 32'(d_q[i]), 32'(exp_d[i]));
        end
        tick();

        // Back-pressure holds the byte and blocks grants.
        do_reset();
        m_ready = 1'b0;
        send(1, 16'h7FFF);
        tick();
        send(1, 16'h0000);
        s_sample[15:0] = 16'h0000;
        s_valid[0] = 1'b1;
        tick();
        for (int n = 0; n < 10; n++) begin
            chk("bp_m_valid", 32'(m_valid), 1);
            chk("bp_m_data", 32'(m_data), 32'hA7);
            chk("bp_m_ch", 32'(m_ch), 1);
            chk("bp_s_ready", 32'(s_ready), 0);
            tick();
        end
        m_ready = 1'b1;
        #1;
        chk("bp_release_m_valid", 32'(m_valid), 1);
        tick();
        chk("bp_after_m_valid", 32'(m_valid), 0);
        chk("bp_after_grant", 32'(s_ready), 32'h1);
        tick();
        s_valid = '0;
        tick();

        // Clear between the two halves of a pair discards the held nibble.
        do_reset();
        send(1, 16'h7FFF);
        tick();
        ch_clear = 4'b0010;
        tick();
        ch_clear = '0;
        send(1, 16'h0000);
        chk("clr_core_pred", 32'(core_pred), 0);
        chk("clr_core_index", 32'(core_index), 0);
        tick();
        chk("clr_no_byte", 32'(m_valid), 0);
        send(1, 16'h0000);
        tick();
        chk("clr_m_valid", 32'(m_valid), 1);
        chk("clr_m_data", 32'(m_data), 32'h00);
        chk("clr_m_ch", 32'(m_ch), 1);
        tick();

        // Clear during ENC of the same channel beats the write-back.
        send(0, 16'h7FFF);
        ch_clear = 4'b0001;
        tick();
        ch_clear = '0;
        chk("clr_enc_m_valid", 32'(m_valid), 0);
        send(0, 16'h7FFF);
        chk("clr_enc_core_pred", 32'(core_pred), 0);
        chk("clr_enc_core_index", 32'(core_index), 0);
        tick();
        chk("clr_enc_no_byte", 32'(m_valid), 0);
        tick();

        // Reset while a byte is pending.
        do_reset();
        m_ready = 1'b0;
        send(0, 16'h7FFF);
        tick();
        send(0, 16'h0000);
        tick();
        chk("rout_m_valid", 32'(m_valid), 1);
        reset = 1'b1;
        tick();
        chk("rout_m_valid_rst", 32'(m_valid), 0);
        chk("rout_m_data_rst", 32'(m_data), 0);
        reset   = 1'b0;
        m_ready = 1'b1;
        tick();
        send(0, 16'h7FFF);
        chk("rout_core_pred", 32'(core_pred), 0);
        chk("rout_core_index", 32'(core_index), 0);
        tick();
        chk("rout_first_half", 32'(m_valid), 0);
        send(0, 16'h0000);
        tick();
        chk("rout_m_valid2", 32'(m_valid), 1);
        chk("rout_m_data2", 32'(m_data), 32'hA7);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
